// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per clock, round keys walked
// backwards from rk10, with the last expanded rk10 cached for back-to-back same-key blocks.
module aes_inv_cipher_iter #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] datain,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dataout
);

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} fsm_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubWord(RotWord(w)); byte 0 of a word sits in bits [31:24]
    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a     = col[31-8*i -: 8];
            x2    = xtime(a);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    fsm_e         fsm_q;
    logic [3:0]   cnt_q;
    logic [127:0] state_q, key_q, orig_key_q;
    logic [127:0] cached_key_q, cached_rk10_q;
    logic         cache_valid_q;
    logic [127:0] dataout_q;
    logic         out_valid_q;

    logic [7:0]   rcon_b;
    logic [31:0]  fwd_t, fw0, fw1, fw2, fw3;
    logic [31:0]  iw0, iw1, iw2, iw3;
    logic [127:0] key_fwd, key_inv;
    logic [127:0] inv_sr_sb, round_add, round_mix, round_d;
    logic         cache_hit;

    // The same counter indexes Rcon in both directions: i while expanding, r while rounding
    assign rcon_b  = rcon(cnt_q);

    assign fwd_t   = sub_rot(key_q[31:0]) ^ {rcon_b, 24'h0};
    assign fw0     = key_q[127:96] ^ fwd_t;
    assign fw1     = key_q[95:64]  ^ fw0;
    assign fw2     = key_q[63:32]  ^ fw1;
    assign fw3     = key_q[31:0]   ^ fw2;
    assign key_fwd = {fw0, fw1, fw2, fw3};

    assign iw3     = key_q[31:0]  ^ key_q[63:32];
    assign iw2     = key_q[63:32] ^ key_q[95:64];
    assign iw1     = key_q[95:64] ^ key_q[127:96];
    assign iw0     = key_q[127:96] ^ sub_rot(iw3) ^ {rcon_b, 24'h0};
    assign key_inv = {iw0, iw1, iw2, iw3};

    // Byte n sits at row n%4, column n/4; row r rotates right by r columns
    always_comb begin
        // NOTE: default every combinational output first so no path can infer a latch.
        inv_sr_sb = '0;
        for (int n = 0; n < 16; n++) begin
            inv_sr_sb[127-8*n -: 8] =
                INV_SBOX[state_q[127-8*((n % 4) + 4*(((n / 4) + 4 - (n % 4)) % 4)) -: 8]];
        end
    end

    assign round_add = inv_sr_sb ^ key_inv;
    assign round_mix = {inv_mix_col(round_add[127:96]), inv_mix_col(round_add[95:64]),
                        inv_mix_col(round_add[63:32]),  inv_mix_col(round_add[31:0])};
    assign round_d   = (cnt_q == 4'd0) ? round_add : round_mix;

    assign cache_hit = (KEY_CACHE != 0) && cache_valid_q && (key == cached_key_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q         <= IDLE;
            cnt_q         <= '0;
            state_q       <= '0;
            key_q         <= '0;
            orig_key_q    <= '0;
            cached_key_q  <= '0;
            cached_rk10_q <= '0;
            cache_valid_q <= 1'b0;
            dataout_q     <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= datain;
                        orig_key_q <= key;
                        if (cache_hit) begin
                            key_q <= cached_rk10_q;
                            fsm_q <= INIT;
                        end else begin
                            key_q <= key;
                            cnt_q <= '0;
                            fsm_q <= KEYEXP;
                        end
                    end
                end
                KEYEXP: begin
                    key_q <= key_fwd;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd9) begin
                        cached_key_q  <= orig_key_q;
                        cached_rk10_q <= key_fwd;
                        cache_valid_q <= 1'b1;
                        fsm_q         <= INIT;
                    end
                end
                INIT: begin
                    state_q <= state_q ^ key_q;
                    cnt_q   <= 4'd9;
                    fsm_q   <= ROUND;
                end
                ROUND: begin
                    state_q <= round_d;
                    key_q   <= key_inv;
                    if (cnt_q == 4'd0) begin
                        dataout_q   <= round_d;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        fsm_q       <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = out_valid_q;
    assign dataout   = dataout_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS vectors, cache/latency, backpressure, reset corners,
// and random blocks against a byte-array AES decryption model.
module tb_aes_inv_cipher_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid, out_ready;
    logic [127:0] datain, key;
    logic         in_ready, out_valid;
    logic [127:0] dataout;
    logic         in_ready0, out_valid0;
    logic [127:0] dataout0;

    always #5 clk = ~clk;

    aes_inv_cipher_iter #(.KEY_CACHE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .datain(datain), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .dataout(dataout)
    );

    aes_inv_cipher_iter #(.KEY_CACHE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .datain(datain), .key(key), .out_valid(out_valid0), .out_ready(out_ready),
        .dataout(dataout0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] m_cache_key;
    bit           m_cache_valid;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    task automatic build_sboxes();
        logic [7:0] inv, v;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            v = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x]  = v;
            isb[v] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]] ^ rc, sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = ct[127-8*n -: 8] ^ w[40 + n/4][31-8*(n%4) -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r + 4*((c + r) % 4)] = s[r + 4*c];
            for (int n = 0; n < 16; n++)
                t[n] = isb[t[n]] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c+0] = gmul(t[4*c], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^ gmul(t[4*c+2], 8'h0d) ^ gmul(t[4*c+3], 8'h09);
                    s[4*c+1] = gmul(t[4*c], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^ gmul(t[4*c+2], 8'h0b) ^ gmul(t[4*c+3], 8'h0d);
                    s[4*c+2] = gmul(t[4*c], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^ gmul(t[4*c+2], 8'h0e) ^ gmul(t[4*c+3], 8'h0b);
                    s[4*c+3] = gmul(t[4*c], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^ gmul(t[4*c+2], 8'h09) ^ gmul(t[4*c+3], 8'h0e);
                end
            end else begin
                for (int n = 0; n < 16; n++) s[n] = t[n];
            end
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic int model_latency(input logic [127:0] k);
        return (m_cache_valid && k == m_cache_key) ? 11 : 21;
    endfunction

    task automatic model_note(input logic [127:0] k);
        m_cache_key   = k;
        m_cache_valid = 1'b1;
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] ct, input logic [127:0] k);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) check("send in_ready timeout", {127'b0, in_ready}, 128'd1);
        in_valid = 1'b1;
        datain   = ct;
        key      = k;
        step();
        in_valid = 1'b0;
        datain   = {$urandom, $urandom, $urandom, $urandom};
        key      = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_out(input bit noise, input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 100) begin
            if (noise) begin
                in_valid = 1'b1;
                datain   = {$urandom, $urandom, $urandom, $urandom};
                key      = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run_block(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] exp_pt,
                             input int exp_lat, input string tag, input bit noise);
        int lat;
        send(ct, k);
        wait_out(noise, 0, lat);
        check({tag, " latency"}, 128'(lat), 128'(exp_lat));
        check({tag, " plaintext"}, dataout, exp_pt);
        model_note(k);
        take_out();
    endtask

    typedef struct {
        logic [127:0] ct;
        logic [127:0] k;
        logic [127:0] pt;
        int           lat;
    } vec_t;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        vec_t         tbl [5];
        logic [127:0] pool [2];
        logic [127:0] k, ct, prev_k;
        int           lat, lat0, n;

        tbl[0] = '{B_CT,  B_KEY,  B_PT,  21};
        tbl[1] = '{B_CT,  B_KEY,  B_PT,  11};
        tbl[2] = '{C1_CT, C1_KEY, C1_PT, 21};
        tbl[3] = '{C1_CT, C1_KEY, C1_PT, 11};
        tbl[4] = '{B_CT,  B_KEY,  B_PT,  21};

        in_valid  = 1'b0;
        out_ready = 1'b0;
        datain    = '0;
        key       = '0;
        m_cache_valid = 1'b0;
        m_cache_key   = '0;
        build_sboxes();

        // Reset values hold regardless of input activity
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            datain    = {$urandom, $urandom, $urandom, $urandom};
            step();
            check("reset in_ready", {127'b0, in_ready}, 128'd1);
            check("reset out_valid", {127'b0, out_valid}, 128'd0);
            check("reset dataout", dataout, 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        step();
        check("post-reset in_ready", {127'b0, in_ready}, 128'd1);
        check("post-reset out_valid", {127'b0, out_valid}, 128'd0);
        check("post-reset dataout", dataout, 128'd0);

        // FIPS-197 C.1 with rk10 observed on INIT entry
        send(C1_CT, C1_KEY);
        repeat (10) step();
        check("C1 rk10 on INIT entry", dut.key_q, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        wait_out(1'b0, 10, lat);
        check("C1 latency", 128'(lat), 128'd21);
        check("C1 plaintext", dataout, C1_PT);
        model_note(C1_KEY);
        take_out();

        // Table: App. B, cache hit, key change, cache hit, key change
        for (int i = 0; i < 5; i++)
            run_block(tbl[i].ct, tbl[i].k, tbl[i].pt, tbl[i].lat, $sformatf("tbl%0d", i), 1'b0);
        check("B cached rk10", dut.cached_rk10_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Backpressure with in_valid noise while busy and in DONE
        send(C1_CT, C1_KEY);
        wait_out(1'b1, 0, lat);
        check("bp latency", 128'(lat), 128'(model_latency(C1_KEY)));
        model_note(C1_KEY);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            datain   = {$urandom, $urandom, $urandom, $urandom};
            step();
            check($sformatf("bp hold out_valid %0d", i), {127'b0, out_valid}, 128'd1);
            check($sformatf("bp hold dataout %0d", i), dataout, C1_PT);
            check($sformatf("bp hold in_ready %0d", i), {127'b0, in_ready}, 128'd0);
        end
        in_valid = 1'b0;
        take_out();
        check("bp release in_ready", {127'b0, in_ready}, 128'd1);
        check("bp release out_valid", {127'b0, out_valid}, 128'd0);
        step();
        check("bp no stray accept", {127'b0, in_ready}, 128'd1);

        // Reset during ROUND r=5 of a cache-hit block
        send(C1_CT, C1_KEY);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("midop out_valid", {127'b0, out_valid}, 128'd0);
        check("midop dataout", dataout, 128'd0);
        check("midop in_ready", {127'b0, in_ready}, 128'd1);
        m_cache_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("midop no output", {127'b0, out_valid}, 128'd0);
        run_block(C1_CT, C1_KEY, C1_PT, 21, "post-midop", 1'b0);

        // KEY_CACHE=0 always re-expands, KEY_CACHE=1 hits on the repeat
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        m_cache_valid = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            send(B_CT, B_KEY);
            lat = -1;
            lat0 = -1;
            n = 0;
            while ((lat < 0 || lat0 < 0) && n < 100) begin
                step();
                n++;
                if (out_valid && lat < 0) lat = n;
                if (out_valid0 && lat0 < 0) lat0 = n;
            end
            check($sformatf("cache1 pass%0d latency", pass), 128'(lat), 128'(pass == 0 ? 21 : 11));
            check($sformatf("cache0 pass%0d latency", pass), 128'(lat0), 128'd21);
            check($sformatf("cache1 pass%0d plaintext", pass), dataout, B_PT);
            check($sformatf("cache0 pass%0d plaintext", pass), dataout0, B_PT);
            model_note(B_KEY);
            take_out();
        end

        // Random blocks against the model, with key reuse to exercise the cache
        pool[0] = {$urandom, $urandom, $urandom, $urandom};
        pool[1] = C1_KEY;
        prev_k  = B_KEY;
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0:       k = pool[0];
                1:       k = pool[1];
                2:       k = prev_k;
                default: k = {$urandom, $urandom, $urandom, $urandom};
            endcase
            ct = {$urandom, $urandom, $urandom, $urandom};
            send(ct, k);
            wait_out(1'($urandom), 0, lat);
            check($sformatf("rand%0d latency", i), 128'(lat), 128'(model_latency(k)));
            check($sformatf("rand%0d plaintext", i), dataout, model_decrypt(ct, k));
            model_note(k);
            prev_k = k;
            repeat ($urandom_range(0, 3)) step();
            take_out();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
